// File: rtl/sti_rx_if.sv
// STI receiver bus: configuration strobe, serial input and parallel result.
interface sti_rx_if #(
    parameter int CNT_W = 8
);
    logic             cfg_load;
    logic [1:0]       cfg_length;
    logic             cfg_fill;
    logic             cfg_msb;
    logic             cfg_low;
    logic             cfg_end;
    logic             si_data;
    logic             si_valid;
    logic [15:0]      po_data;
    logic             po_valid;
    logic             po_err;
    logic [CNT_W-1:0] po_count;
    logic             rx_done;

    modport master (
        output cfg_load, cfg_length, cfg_fill, cfg_msb, cfg_low, cfg_end,
        output si_data, si_valid,
        input  po_data, po_valid, po_err, po_count, rx_done
    );

    modport slave (
        input  cfg_load, cfg_length, cfg_fill, cfg_msb, cfg_low, cfg_end,
        input  si_data, si_valid,
        output po_data, po_valid, po_err, po_count, rx_done
    );
endinterface

// File: rtl/sti_rx.sv
// STI serial-to-parallel receiver: rebuilds 16-bit words from 8/16/24/32-bit
// serial frames, flags short frames and nonzero fill bits, counts good words.
module sti_rx #(
    parameter int CNT_W = 8
) (
    input  logic    clk,
    input  logic    reset,
    sti_rx_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RECV, DONE} state_t;

    state_t           state_reg, state_next;
    logic [4:0]       cnt_reg, cnt_next;
    logic [31:0]      w_reg, w_next;

    logic [1:0]       cfg_length_reg;
    logic             cfg_fill_reg, cfg_msb_reg, cfg_low_reg, cfg_end_reg;
    logic [1:0]       snap_length_reg, snap_length_next;
    logic             snap_fill_reg, snap_fill_next;
    logic             snap_msb_reg, snap_msb_next;
    logic             snap_low_reg, snap_low_next;
    logic             snap_end_reg, snap_end_next;

    logic [15:0]      po_data_reg;
    logic             po_valid_reg, po_err_reg, rx_done_reg;
    logic [CNT_W-1:0] po_count_reg;

    // A cfg_load coinciding with a frame's first bit must reach the snapshot.
    logic [1:0]       eff_length;
    logic             eff_fill, eff_msb, eff_low, eff_end;
    logic [1:0]       use_length;
    logic             use_msb;
    logic [4:0]       last_idx, bit_pos;
    logic             frame_done, frame_short;
    logic [15:0]      word;
    logic             fill_err;

    // Effective configuration: live inputs bypass the registers on a load cycle.
    always_comb begin
        eff_length = bus.cfg_load ? bus.cfg_length : cfg_length_reg;
        eff_fill   = bus.cfg_load ? bus.cfg_fill   : cfg_fill_reg;
        eff_msb    = bus.cfg_load ? bus.cfg_msb    : cfg_msb_reg;
        eff_low    = bus.cfg_load ? bus.cfg_low    : cfg_low_reg;
        eff_end    = bus.cfg_load ? bus.cfg_end    : cfg_end_reg;
    end

    // Next-state logic: bit placement, frame completion and short-frame detection.
    always_comb begin
        state_next       = state_reg;
        cnt_next         = cnt_reg;
        w_next           = w_reg;
        snap_length_next = snap_length_reg;
        snap_fill_next   = snap_fill_reg;
        snap_msb_next    = snap_msb_reg;
        snap_low_next    = snap_low_reg;
        snap_end_next    = snap_end_reg;
        frame_done       = 1'b0;
        frame_short      = 1'b0;

        // In IDLE the incoming bit is bit 0 of a new frame, so the live config decides its slot.
        use_length = (state_reg == IDLE) ? eff_length : snap_length_reg;
        use_msb    = (state_reg == IDLE) ? eff_msb    : snap_msb_reg;
        last_idx   = {use_length, 3'b111};
        bit_pos    = use_msb ? (last_idx - cnt_reg) : cnt_reg;

        case (state_reg)
            IDLE: begin
                if (bus.si_valid) begin
                    w_next           = 32'd0;
                    w_next[bit_pos]  = bus.si_data;
                    snap_length_next = eff_length;
                    snap_fill_next   = eff_fill;
                    snap_msb_next    = eff_msb;
                    snap_low_next    = eff_low;
                    snap_end_next    = eff_end;
                    cnt_next         = 5'd1;
                    state_next       = RECV;
                end
            end
            RECV: begin
                if (bus.si_valid) begin
                    w_next[bit_pos] = bus.si_data;
                    if (cnt_reg == last_idx) begin
                        frame_done = 1'b1;
                        cnt_next   = 5'd0;
                        state_next = snap_end_reg ? DONE : IDLE;
                    end else begin
                        cnt_next = cnt_reg + 5'd1;
                    end
                end else begin
                    frame_short = 1'b1;
                    cnt_next    = 5'd0;
                    state_next  = snap_end_reg ? DONE : IDLE;
                end
            end
            DONE: begin
                state_next = DONE;
            end
            default: begin
                state_next = IDLE;
                cnt_next   = 5'd0;
            end
        endcase
    end

    // Word extraction and fill-bit check on the completed frame image.
    always_comb begin
        word     = w_next[15:0];
        fill_err = 1'b0;
        case (snap_length_next)
            2'd0: word = snap_low_next ? {w_next[7:0], 8'h00} : {8'h00, w_next[7:0]};
            2'd1: word = w_next[15:0];
            2'd2: begin
                word     = snap_fill_next ? w_next[23:8] : w_next[15:0];
                fill_err = snap_fill_next ? (|w_next[7:0]) : (|w_next[23:16]);
            end
            default: begin
                word     = snap_fill_next ? w_next[31:16] : w_next[15:0];
                fill_err = snap_fill_next ? (|w_next[15:0]) : (|w_next[31:16]);
            end
        endcase
    end

    // Configuration registers, loadable in any state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cfg_length_reg <= 2'd0;
            cfg_fill_reg   <= 1'b0;
            cfg_msb_reg    <= 1'b0;
            cfg_low_reg    <= 1'b0;
            cfg_end_reg    <= 1'b0;
        end else if (bus.cfg_load) begin
            cfg_length_reg <= bus.cfg_length;
            cfg_fill_reg   <= bus.cfg_fill;
            cfg_msb_reg    <= bus.cfg_msb;
            cfg_low_reg    <= bus.cfg_low;
            cfg_end_reg    <= bus.cfg_end;
        end
    end

    // FSM state, bit counter, frame image and per-frame config snapshot.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg       <= IDLE;
            cnt_reg         <= 5'd0;
            w_reg           <= 32'd0;
            snap_length_reg <= 2'd0;
            snap_fill_reg   <= 1'b0;
            snap_msb_reg    <= 1'b0;
            snap_low_reg    <= 1'b0;
            snap_end_reg    <= 1'b0;
        end else begin
            state_reg       <= state_next;
            cnt_reg         <= cnt_next;
            w_reg           <= w_next;
            snap_length_reg <= snap_length_next;
            snap_fill_reg   <= snap_fill_next;
            snap_msb_reg    <= snap_msb_next;
            snap_low_reg    <= snap_low_next;
            snap_end_reg    <= snap_end_next;
        end
    end

    // Output pulses, held word, good-frame counter and sticky done flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            po_data_reg  <= 16'd0;
            po_valid_reg <= 1'b0;
            po_err_reg   <= 1'b0;
            po_count_reg <= '0;
            rx_done_reg  <= 1'b0;
        end else begin
            po_valid_reg <= frame_done;
            po_err_reg   <= frame_short | (frame_done & fill_err);
            rx_done_reg  <= (state_next == DONE);
            if (frame_done) begin
                po_data_reg <= word;
            end
            if (frame_done && !fill_err) begin
                po_count_reg <= po_count_reg + 1'b1;
            end
        end
    end

    assign bus.po_data  = po_data_reg;
    assign bus.po_valid = po_valid_reg;
    assign bus.po_err   = po_err_reg;
    assign bus.po_count = po_count_reg;
    assign bus.rx_done  = rx_done_reg;
endmodule

// File: tb/tb_sti_rx.sv
// Self-checking bench for sti_rx: directed frames, a frame-level reference
// model feeding a per-cycle compare process, and literal spot checks.
module tb_sti_rx;
    logic clk;
    logic reset;
    int   cyc;
    int   n_checks;
    int   n_fail;
    bit   drv_done;

    sti_rx_if #(.CNT_W(8)) bus ();

    sti_rx #(.CNT_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int          at;
        bit          valid;
        bit          err;
        logic [15:0] data;
        bit          endf;
    } ev_t;

    ev_t         q[$];
    logic [15:0] m_data;
    logic [7:0]  m_count;
    bit          m_done;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // cycle index of the most recent rising edge
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // Frame-level reference: what the receiver must output for a frame word w.
    function automatic void model(input logic [1:0] len, input bit fill, input bit low,
                                  input logic [31:0] w, output logic [15:0] d, output bit e);
        int          n;
        logic [63:0] wn;
        logic [15:0] b;
        n  = 8 * (int'(len) + 1);
        wn = {32'd0, w} & ((64'd1 << n) - 64'd1);
        e  = 1'b0;
        if (n == 8) begin
            b = 16'(wn & 64'hFF);
            d = low ? (b << 8) : b;
        end else if (n == 16) begin
            d = 16'(wn);
        end else if (fill) begin
            d = 16'(wn >> (n - 16));
            e = (wn & ((64'd1 << (n - 16)) - 64'd1)) != 64'd0;
        end else begin
            d = 16'(wn);
            e = (wn >> 16) != 64'd0;
        end
    endfunction

    // Per-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        bit exp_valid;
        bit exp_err;
        exp_valid = 1'b0;
        exp_err   = 1'b0;
        while (q.size() > 0 && q[0].at < cyc) begin
            n_checks++;
            n_fail++;
            $display("FAIL missed_event at cycle %0d: got none, expected event due at cycle %0d", cyc, q[0].at);
            void'(q.pop_front());
        end
        if (q.size() > 0 && q[0].at == cyc) begin
            ev_t ev;
            ev        = q.pop_front();
            exp_valid = ev.valid;
            exp_err   = ev.err;
            if (ev.valid) m_data = ev.data;
            if (ev.valid && !ev.err) m_count = m_count + 8'd1;
            if (ev.endf) m_done = 1'b1;
        end
        chk("po_valid", 32'(bus.po_valid), 32'(exp_valid));
        chk("po_err",   32'(bus.po_err),   32'(exp_err));
        chk("po_data",  32'(bus.po_data),  32'(m_data));
        chk("po_count", 32'(bus.po_count), 32'(m_count));
        chk("rx_done",  32'(bus.rx_done),  32'(m_done));
    end

    // Sends nsend bits of a frame, loading cfg with the first bit.
    task automatic send(input logic [1:0] len, input bit fill, input bit msb, input bit low,
                        input bit endf, input logic [31:0] w, input int nsend);
        int          n;
        logic [15:0] d;
        bit          e;
        ev_t         ev;
        n = 8 * (int'(len) + 1);
        model(len, fill, low, w, d, e);
        $display("frame len=%0d fill=%0d msb=%0d low=%0d end=%0d w=%08h bits=%0d/%0d ignored=%0d",
                 n, fill, msb, low, endf, w, nsend, n, drv_done);
        for (int k = 0; k < nsend; k++) begin
            bus.cfg_length = len;
            bus.cfg_fill   = fill;
            bus.cfg_msb    = msb;
            bus.cfg_low    = low;
            bus.cfg_end    = endf;
            bus.cfg_load   = (k == 0);
            bus.si_valid   = 1'b1;
            bus.si_data    = msb ? w[n - 1 - k] : w[k];
            if (k == nsend - 1 && !drv_done) begin
                ev.at    = (nsend == n) ? cyc + 1 : cyc + 2;
                ev.valid = (nsend == n);
                ev.err   = (nsend < n) || e;
                ev.data  = d;
                ev.endf  = endf;
                q.push_back(ev);
                if (endf) drv_done = 1'b1;
            end
            @(posedge clk); #1;
        end
        bus.cfg_load = 1'b0;
    endtask

    task automatic idle(input int n);
        bus.si_valid = 1'b0;
        bus.si_data  = 1'b0;
        bus.cfg_load = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks = 0; n_fail = 0; cyc = 0; drv_done = 1'b0;
        m_data = 16'd0; m_count = 8'd0; m_done = 1'b0;
        reset = 1'b1;
        bus.cfg_load = 1'b0; bus.cfg_length = 2'd0; bus.cfg_fill = 1'b0;
        bus.cfg_msb = 1'b0; bus.cfg_low = 1'b0; bus.cfg_end = 1'b0;
        bus.si_data = 1'b0; bus.si_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_po_data", 32'(bus.po_data), 32'h0);
        chk("reset_po_count", 32'(bus.po_count), 32'h0);
        reset = 1'b0;
        idle(2);

        // 8b msb-first 1,1,0,0,0,0,1,1
        send(2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_00C3, 8);
        idle(3);
        chk("lit_8b_msb_data", 32'(bus.po_data), 32'h00C3);
        chk("lit_8b_msb_count", 32'(bus.po_count), 32'd1);

        // 8b lsb-first, byte in upper half
        send(2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_00A5, 8);
        idle(3);
        chk("lit_8b_low_data", 32'(bus.po_data), 32'hA500);

        // 16b then 32b back-to-back with cfg reloaded on the second frame's first bit
        send(2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_1234, 16);
        send(2'd3, 1'b1, 1'b1, 1'b0, 1'b0, 32'hBEEF_0000, 32);
        idle(3);
        chk("lit_b2b_data", 32'(bus.po_data), 32'hBEEF);
        chk("lit_b2b_count", 32'(bus.po_count), 32'd4);

        // 24b fill=0 with a nonzero top fill byte
        send(2'd2, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0001_5A5A, 24);
        idle(3);
        chk("lit_fill_err_data", 32'(bus.po_data), 32'h5A5A);
        chk("lit_fill_err_count", 32'(bus.po_count), 32'd4);

        // short 8b frame followed by a good one
        send(2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_00FF, 5);
        idle(3);
        chk("lit_short_data_held", 32'(bus.po_data), 32'h5A5A);
        send(2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_003C, 8);
        idle(3);
        chk("lit_after_short_data", 32'(bus.po_data), 32'h003C);
        chk("lit_after_short_count", 32'(bus.po_count), 32'd5);

        // 251 more good frames back-to-back drive the counter through its wrap
        for (int i = 0; i < 251; i++) begin
            send(2'd0, 1'b0, 1'(i % 2), 1'b0, 1'b0, 32'($urandom_range(255)), 8);
        end
        idle(3);
        chk("lit_count_wrap", 32'(bus.po_count), 32'd0);

        // reset in the middle of a 32b frame
        send(2'd3, 1'b0, 1'b1, 1'b0, 1'b0, 32'h1234_5678, 10);
        reset = 1'b1;
        q.delete();
        m_data = 16'd0; m_count = 8'd0; m_done = 1'b0; drv_done = 1'b0;
        #1;
        chk("lit_rst_data", 32'(bus.po_data), 32'h0);
        chk("lit_rst_valid", 32'(bus.po_valid), 32'h0);
        chk("lit_rst_err", 32'(bus.po_err), 32'h0);
        idle(2);
        reset = 1'b0;
        idle(2);

        // last frame sets rx_done; a following frame is ignored
        send(2'd1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_CAFE, 16);
        idle(3);
        send(2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0011, 8);
        idle(3);
        chk("lit_done_flag", 32'(bus.rx_done), 32'd1);
        chk("lit_done_data", 32'(bus.po_data), 32'hCAFE);
        chk("lit_done_count", 32'(bus.po_count), 32'd1);
        chk("queue_drained", 32'(q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
